// File: rtl/dvi_timing_gen.sv
// DVI/VGA raster timing generator: IDLE/RUN/DRAIN sequencer, registered sync/de/coordinates.
// Optional frame counter output enabled by defining DVI_TIMING_FRAME_COUNT_EN.
module dvi_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter int SYNC_POL = 1
) (
  input  logic       pixelClk,
  input  logic       aRst_n,
  input  logic       enable,
  output logic       stopped,
  output logic       hs,
  output logic       vs,
  output logic       de,
  output logic [9:0] pixelX,
  output logic [9:0] pixelY
`ifdef DVI_TIMING_FRAME_COUNT_EN
  ,
  output logic [7:0] frameCount
`endif
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST  = 11'(HT - 1);
  localparam logic [10:0] V_LAST  = 11'(VT - 1);
  localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        SYNC_ON = (SYNC_POL != 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] h_q, h_d;
  logic [10:0] v_q, v_d;
  logic        stopped_q, stopped_d;
  logic        de_q, de_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic [9:0]  px_q, px_d;
  logic [9:0]  py_q, py_d;

  logic running;
  logic h_last;
  logic v_last;
  logic frame_end;
  logic de_act;
  logic hs_act;
  logic vs_act;

  assign running   = (state_q != ST_IDLE);
  assign h_last    = (h_q == H_LAST);
  assign v_last    = (v_q == V_LAST);
  assign frame_end = running && h_last && v_last;

  // Sequencer and raster counters; RUN and DRAIN only differ in whether the
  // frame boundary is allowed to drop back to IDLE.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    case (state_q)
      ST_IDLE: begin
        h_d = '0;
        v_d = '0;
        if (enable) state_d = ST_RUN;
      end
      ST_RUN, ST_DRAIN: begin
        if (h_last) begin
          h_d = '0;
          v_d = v_last ? '0 : v_q + 11'd1;
        end else begin
          h_d = h_q + 11'd1;
        end
        if (frame_end && !enable) state_d = ST_IDLE;
        else                      state_d = enable ? ST_RUN : ST_DRAIN;
      end
      default: begin
        state_d = ST_IDLE;
        h_d     = '0;
        v_d     = '0;
      end
    endcase
  end

  // Output decode from the current counters, registered one clock later.
  always_comb begin
    de_act    = running && (h_q < H_ACT) && (v_q < V_ACT);
    hs_act    = running && (h_q >= HS_BEG) && (h_q < HS_END);
    vs_act    = running && (v_q >= VS_BEG) && (v_q < VS_END);
    de_d      = de_act;
    hs_d      = hs_act ? SYNC_ON : ~SYNC_ON;
    vs_d      = vs_act ? SYNC_ON : ~SYNC_ON;
    px_d      = de_act ? h_q[9:0] : '0;
    py_d      = de_act ? v_q[9:0] : '0;
    stopped_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge pixelClk or negedge aRst_n) begin
    if (!aRst_n) begin
      state_q   <= ST_IDLE;
      h_q       <= '0;
      v_q       <= '0;
      stopped_q <= 1'b1;
      de_q      <= 1'b0;
      hs_q      <= ~SYNC_ON;
      vs_q      <= ~SYNC_ON;
      px_q      <= '0;
      py_q      <= '0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      v_q       <= v_d;
      stopped_q <= stopped_d;
      de_q      <= de_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      px_q      <= px_d;
      py_q      <= py_d;
    end
  end

  assign stopped = stopped_q;
  assign de      = de_q;
  assign hs      = hs_q;
  assign vs      = vs_q;
  assign pixelX  = px_q;
  assign pixelY  = py_q;

`ifdef DVI_TIMING_FRAME_COUNT_EN
  logic [7:0] frame_q, frame_d;

  always_comb begin
    frame_d = frame_q;
    if (frame_end) frame_d = frame_q + 8'd1;
  end

  always_ff @(posedge pixelClk or negedge aRst_n) begin
    if (!aRst_n) frame_q <= '0;
    else         frame_q <= frame_d;
  end

  assign frameCount = frame_q;
`endif

endmodule

// File: tb/tb_dvi_timing_gen.sv
// Bench for dvi_timing_gen: small raster, position-based reference model, two sync polarities.
module tb_dvi_timing_gen;

  localparam int HA = 16, HF = 3, HS = 4, HB = 5;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       stopped, hs, vs, de;
  logic [9:0] pixelX, pixelY;
  logic       stopped_n, hs_n, vs_n, de_n;
  logic [9:0] pixelX_n, pixelY_n;
`ifdef DVI_TIMING_FRAME_COUNT_EN
  logic [7:0] frameCount, frameCount_n;
`endif

  always #5 clk = ~clk;

  dvi_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1)
  ) u_dut (
    .pixelClk(clk), .aRst_n(rst_n), .enable(enable), .stopped(stopped),
    .hs(hs), .vs(vs), .de(de), .pixelX(pixelX), .pixelY(pixelY)
`ifdef DVI_TIMING_FRAME_COUNT_EN
    , .frameCount(frameCount)
`endif
  );

  dvi_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(0)
  ) u_dut_n (
    .pixelClk(clk), .aRst_n(rst_n), .enable(enable), .stopped(stopped_n),
    .hs(hs_n), .vs(vs_n), .de(de_n), .pixelX(pixelX_n), .pixelY(pixelY_n)
`ifdef DVI_TIMING_FRAME_COUNT_EN
    , .frameCount(frameCount_n)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: running flag plus linear position within the frame.
  int          m_run;
  int          m_pos;
  int          m_frames;
  logic [23:0] m_exp;

  function automatic logic [23:0] exp_of(int pos);
    int   x, y;
    logic d, h, v;
    x = pos % HT;
    y = pos / HT;
    d = (x < HA) && (y < VA);
    h = (x >= HA + HF) && (x < HA + HF + HS);
    v = (y >= VA + VF) && (y < VA + VF + VS);
    return {1'b0, d, h, v, d ? 10'(x) : 10'd0, d ? 10'(y) : 10'd0};
  endfunction

  function automatic logic [23:0] got_vec();
    return {stopped, de, hs, vs, pixelX, pixelY};
  endfunction

  function automatic logic [23:0] got_vec_n();
    return {stopped_n, de_n, ~hs_n, ~vs_n, pixelX_n, pixelY_n};
  endfunction

  task automatic model_reset();
    m_run    = 0;
    m_pos    = 0;
    m_frames = 0;
    m_exp    = 24'h800000;
  endtask

  task automatic adv();
    @(posedge clk);
    if (m_run != 0) begin
      m_exp = exp_of(m_pos);
      if (m_pos == FT - 1) begin
        m_frames = (m_frames + 1) % 256;
        if (!enable) m_run = 0;
      end
      m_pos = (m_pos + 1) % FT;
    end else begin
      m_exp = '0;
      m_pos = 0;
      m_run = enable ? 1 : 0;
    end
    m_exp[23] = (m_run == 0);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (got_vec() !== 24'h800000) begin
      failures++; $display("FAIL reset_idle got=%h exp=%h", got_vec(), 24'h800000);
    end
    checks++;
    if (got_vec_n() !== 24'h800000) begin
      failures++; $display("FAIL reset_idle_n got=%h exp=%h", got_vec_n(), 24'h800000);
    end
`ifdef DVI_TIMING_FRAME_COUNT_EN
    checks++;
    if (frameCount !== 8'd0) begin
      failures++; $display("FAIL reset_frame got=%0d exp=0", frameCount);
    end
`endif
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      adv();
      checks++;
      if (got_vec() !== m_exp) begin
        failures++; $display("FAIL idle_hold cyc=%0d got=%h exp=%h", i, got_vec(), m_exp);
      end
    end
  endtask

  task automatic test_start();
    int de_cnt;
    enable = 1'b1;
    adv();
    checks++;
    if (got_vec() !== m_exp) begin
      failures++; $display("FAIL start_enter got=%h exp=%h", got_vec(), m_exp);
    end
    adv();
    checks++;
    if (de !== 1'b1 || pixelX !== 10'd0 || pixelY !== 10'd0 || stopped !== 1'b0) begin
      failures++;
      $display("FAIL start_first de=%b x=%0d y=%0d stopped=%b exp de=1 x=0 y=0 stopped=0",
               de, pixelX, pixelY, stopped);
    end
    de_cnt = 1;
    for (int i = 1; i < 2 * FT; i++) begin
      adv();
      checks++;
      if (got_vec() !== m_exp) begin
        failures++; $display("FAIL start_model cyc=%0d got=%h exp=%h", i, got_vec(), m_exp);
      end
      checks++;
      if (got_vec_n() !== m_exp) begin
        failures++; $display("FAIL start_model_n cyc=%0d got=%h exp=%h", i, got_vec_n(), m_exp);
      end
      if (i < HT && de === 1'b1) de_cnt++;
    end
    checks++;
    if (de_cnt != HA) begin
      failures++; $display("FAIL start_de_per_line got=%0d exp=%0d", de_cnt, HA);
    end
  endtask

  task automatic test_free_run();
    int   cyc, last_hs, last_line, last_frame, vs_rise, n_frames;
    logic phs, pvs;
    cyc = 0; last_hs = -1; last_line = -1; last_frame = -1; vs_rise = -1; n_frames = 0;
    phs = hs; pvs = vs;
    for (int i = 0; i < 3 * FT; i++) begin
      adv();
      cyc++;
      checks++;
      if (got_vec() !== m_exp) begin
        failures++; $display("FAIL free_model cyc=%0d got=%h exp=%h", i, got_vec(), m_exp);
      end
      if (de === 1'b1 && pixelX == 10'd0) last_line = cyc;
      if (de === 1'b1 && pixelX == 10'd0 && pixelY == 10'd0) begin
        if (last_frame >= 0) begin
          checks++;
          if (cyc - last_frame != FT) begin
            failures++; $display("FAIL free_frame_period got=%0d exp=%0d", cyc - last_frame, FT);
          end
        end
        last_frame = cyc;
        n_frames++;
      end
      if (hs === 1'b1 && phs === 1'b0) begin
        if (last_hs >= 0) begin
          checks++;
          if (cyc - last_hs != HT) begin
            failures++; $display("FAIL free_line_period got=%0d exp=%0d", cyc - last_hs, HT);
          end
        end
        if (last_line >= 0 && cyc - last_line < HT) begin
          checks++;
          if (cyc - last_line != HA + HF) begin
            failures++; $display("FAIL free_hs_offset got=%0d exp=%0d", cyc - last_line, HA + HF);
          end
        end
        last_hs = cyc;
      end
      if (hs === 1'b0 && phs === 1'b1 && last_hs >= 0) begin
        checks++;
        if (cyc - last_hs != HS) begin
          failures++; $display("FAIL free_hs_width got=%0d exp=%0d", cyc - last_hs, HS);
        end
      end
      if (vs === 1'b1 && pvs === 1'b0) begin
        vs_rise = cyc;
        if (last_frame >= 0) begin
          checks++;
          if (cyc - last_frame != (VA + VF) * HT) begin
            failures++; $display("FAIL free_vs_offset got=%0d exp=%0d", cyc - last_frame, (VA + VF) * HT);
          end
        end
      end
      if (vs === 1'b0 && pvs === 1'b1 && vs_rise >= 0) begin
        checks++;
        if (cyc - vs_rise != VS * HT) begin
          failures++; $display("FAIL free_vs_width got=%0d exp=%0d", cyc - vs_rise, VS * HT);
        end
      end
      phs = hs; pvs = vs;
    end
    checks++;
    if (n_frames != 3) begin
      failures++; $display("FAIL free_frame_count got=%0d exp=3", n_frames);
    end
  endtask

  task automatic test_drain();
    int target, p, n;
    target = $urandom_range(1, VA - 1) * HT;
    for (int i = 0; i < 2 * FT && m_pos != target; i++) begin
      adv();
      checks++;
      if (got_vec() !== m_exp) begin
        failures++; $display("FAIL drain_pre cyc=%0d got=%h exp=%h", i, got_vec(), m_exp);
      end
    end
    p = m_pos;
    enable = 1'b0;
    n = 0;
    for (int i = 0; i < 2 * FT; i++) begin
      adv();
      n++;
      checks++;
      if (got_vec() !== m_exp) begin
        failures++; $display("FAIL drain_model cyc=%0d got=%h exp=%h", i, got_vec(), m_exp);
      end
      if (stopped === 1'b1) break;
    end
    checks++;
    if (n != FT - p || stopped !== 1'b1) begin
      failures++; $display("FAIL drain_length got=%0d stopped=%b exp=%0d stopped=1", n, stopped, FT - p);
    end
    for (int i = 0; i < 3 * HT; i++) begin
      adv();
      checks++;
      if (de !== 1'b0 || stopped !== 1'b1 || got_vec() !== m_exp) begin
        failures++; $display("FAIL drain_idle cyc=%0d got=%h exp=%h", i, got_vec(), m_exp);
      end
    end
  endtask

  task automatic test_toggle();
    int cyc, start, de_cnt, k;
    logic found;
    enable = 1'b1;
    cyc = 0; start = -1; found = 1'b0;
    for (int i = 0; i < 2 * FT; i++) begin
      adv();
      cyc++;
      if (de === 1'b1 && pixelX == 10'd0 && pixelY == 10'd0) begin start = cyc; break; end
    end
    checks++;
    if (start < 0) begin
      failures++; $display("FAIL toggle_start_timeout got=none exp=frame start");
    end
    de_cnt = 1;
    k = $urandom_range(1, 2 * HT);
    for (int i = 0; i < 3 * FT; i++) begin
      if (i == 2 * HT) enable = 1'b0;
      if (i == 2 * HT + k) enable = 1'b1;
      adv();
      cyc++;
      checks++;
      if (got_vec() !== m_exp) begin
        failures++; $display("FAIL toggle_model cyc=%0d got=%h exp=%h", i, got_vec(), m_exp);
      end
      if (de === 1'b1 && pixelX == 10'd0 && pixelY == 10'd0) begin found = 1'b1; break; end
      if (de === 1'b1) de_cnt++;
    end
    checks++;
    if (!found || cyc - start != FT) begin
      failures++; $display("FAIL toggle_period got=%0d exp=%0d", cyc - start, FT);
    end
    checks++;
    if (de_cnt != HA * VA) begin
      failures++; $display("FAIL toggle_de_count got=%0d exp=%0d", de_cnt, HA * VA);
    end
  endtask

  task automatic test_async_reset();
    int target;
    target = 2 * HT + HA / 2;
    for (int i = 0; i < 2 * FT && m_pos != target; i++) begin
      adv();
      checks++;
      if (got_vec() !== m_exp) begin
        failures++; $display("FAIL arst_pre cyc=%0d got=%h exp=%h", i, got_vec(), m_exp);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (got_vec() !== 24'h800000) begin
      failures++; $display("FAIL arst_immediate got=%h exp=%h", got_vec(), 24'h800000);
    end
    checks++;
    if (got_vec_n() !== 24'h800000) begin
      failures++; $display("FAIL arst_immediate_n got=%h exp=%h", got_vec_n(), 24'h800000);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    adv();
    checks++;
    if (got_vec() !== m_exp) begin
      failures++; $display("FAIL arst_enter got=%h exp=%h", got_vec(), m_exp);
    end
    adv();
    checks++;
    if (de !== 1'b1 || pixelX !== 10'd0 || pixelY !== 10'd0) begin
      failures++; $display("FAIL arst_restart de=%b x=%0d y=%0d exp de=1 x=0 y=0", de, pixelX, pixelY);
    end
    for (int i = 0; i < FT; i++) begin
      adv();
      checks++;
      if (got_vec() !== m_exp) begin
        failures++; $display("FAIL arst_model cyc=%0d got=%h exp=%h", i, got_vec(), m_exp);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      adv();
      checks++;
      if (got_vec() !== m_exp) begin
        failures++; $display("FAIL rand_model cyc=%0d got=%h exp=%h", i, got_vec(), m_exp);
      end
      checks++;
      if (got_vec_n() !== m_exp) begin
        failures++; $display("FAIL rand_model_n cyc=%0d got=%h exp=%h", i, got_vec_n(), m_exp);
      end
`ifdef DVI_TIMING_FRAME_COUNT_EN
      checks++;
      if (frameCount !== 8'(m_frames)) begin
        failures++; $display("FAIL rand_frame cyc=%0d got=%0d exp=%0d", i, frameCount, m_frames);
      end
`endif
    end
  endtask

`ifdef DVI_TIMING_FRAME_COUNT_EN
  task automatic test_frame_count();
    #2;
    rst_n  = 1'b0;
    enable = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    adv();
    for (int i = 0; i < 3 * FT; i++) adv();
    checks++;
    if (frameCount !== 8'd3 || frameCount_n !== 8'd3) begin
      failures++; $display("FAIL frame_count3 got=%0d/%0d exp=3", frameCount, frameCount_n);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_start();
    test_free_run();
    test_drain();
    test_toggle();
    test_async_reset();
    test_random();
`ifdef DVI_TIMING_FRAME_COUNT_EN
    test_frame_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dvi_timing_gen.md
DVI_TIMING_GEN -- requirements
Module: dvi_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 800, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 40, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 128, hsync width in pixels.
REQ-004 SHALL have parameter H_BP, default 88, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 600, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 1, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 4, vsync width in lines.
REQ-008 SHALL have parameter V_BP, default 23, vertical back porch in lines.
REQ-009 SHALL have parameter SYNC_POL, default 1, 1 = active-high syncs, 0 = active-low syncs.
REQ-010 SHALL have port pixelClk, input, 1, pixel clock; the only clock in the block.
REQ-011 SHALL have port aRst_n, input, 1, asynchronous active-low reset.
REQ-012 SHALL have port enable, input, 1, run request.
REQ-013 SHALL have port stopped, output, 1, high while the generator is idle.
REQ-014 SHALL have ports hs and vs, outputs, 1 each, horizontal and vertical sync at SYNC_POL polarity.
REQ-015 SHALL have port de, output, 1, active-video flag.
REQ-016 SHALL have ports pixelX and pixelY, outputs, 10 each, active-area coordinates.

Function
REQ-017 SHALL hold an 11-bit hCnt (0..HT-1, HT = H_ACTIVE+H_FP+H_SYNC+H_BP) and an 11-bit vCnt (0..VT-1, VT = V_ACTIVE+V_FP+V_SYNC+V_BP).
- hCnt=0 is the first active pixel of a line; vCnt=0 is the first active line of a frame.
REQ-018 SHALL use a three-state FSM:
- IDLE -> RUN when enable=1; counters start at (0,0).
- RUN -> DRAIN when enable=0.
- DRAIN -> RUN when enable=1 again, with no counter disturbance.
- RUN or DRAIN -> IDLE on the cycle after hCnt=HT-1 and vCnt=VT-1, if enable=0 on that cycle.
REQ-019 In RUN and DRAIN, SHALL advance hCnt every clock and wrap it to 0 after HT-1; SHALL increment vCnt on that wrap and wrap it to 0 after VT-1.
REQ-020 SHALL register all outputs, so that de/hs/vs/pixelX/pixelY reflect the counter values of the previous clock, mutually aligned (latency 1).
REQ-021 SHALL assert de iff hCnt<H_ACTIVE and vCnt<V_ACTIVE.
REQ-022 SHALL assert hs when H_ACTIVE+H_FP <= hCnt < H_ACTIVE+H_FP+H_SYNC.
REQ-023 SHALL assert vs when V_ACTIVE+V_FP <= vCnt < V_ACTIVE+V_FP+V_SYNC, for whole lines aligned to hCnt=0.
REQ-024 SHALL drive pixelX=hCnt[9:0] and pixelY=vCnt[9:0] when de=1, and 0 when de=0.
REQ-025 In IDLE, SHALL drive de=0, hs and vs inactive, pixelX=pixelY=0, stopped=1, and hold the counters at 0; stopped SHALL be 0 in RUN and DRAIN.
REQ-026 Frame length SHALL be HT*VT clocks exactly; enable toggling mid-frame SHALL NOT truncate or lengthen a frame.

Reset
REQ-027 On aRst_n=0, SHALL asynchronously force: FSM=IDLE, counters=0, stopped=1, de=0, hs and vs inactive, pixelX=pixelY=0.
REQ-028 Reset deasserted mid-frame SHALL restart from IDLE; the first frame after release SHALL begin at (0,0).

Configuration
REQ-029 With macro DVI_TIMING_FRAME_COUNT_EN defined:
- SHALL add output frameCount [7:0], reset 0.
- frameCount SHALL increment (wrapping 255->0) on each transition to vCnt=0 while in RUN or DRAIN.
- frameCount SHALL hold its value in IDLE.
REQ-030 Without DVI_TIMING_FRAME_COUNT_EN, the frameCount port and its logic SHALL be absent.

Verification
REQ-031 Reset then enable=1 with default parameters -> de=1 with pixelX=0, pixelY=0 one clock after leaving IDLE; de high for exactly 800 clocks per line.
REQ-032 Free run -> hs high for 128 clocks starting 840 clocks after line start; line period 1056; vs high for 4 lines starting at line 601; frame 663168 clocks.
REQ-033 enable dropped at line 300 -> frame completes to vCnt=627, hCnt=1055; stopped=1 on the next clock with all outputs idle; no further de.
REQ-034 enable dropped then re-raised within the same frame -> no gap, and the frame period stays 663168.
REQ-035 aRst_n pulsed low mid-line at hCnt=400 -> outputs go idle immediately with stopped=1; on release with enable=1, restart at (0,0).
REQ-036 SYNC_POL=0 and DVI_TIMING_FRAME_COUNT_EN defined -> hs/vs idle high and pulse low; frameCount reads 3 after three complete frames.
